// File: rtl/uvc_payload_gen.sv
// UVC payload generator: packs YUY2 test-pattern frames into 12-byte-header UVC payloads,
// one frame per SOF slot, for the USB video endpoint TX FIFO.
//
// state | meaning
// IDLE  | waiting for an enabled frame slot (sof_cnt == 0)
// HDR   | emitting the 12 header bytes of a payload
// DATA  | emitting pixel bytes of the current payload
module uvc_payload_gen #(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int PAYLOAD_SIZE   = 1024,
  parameter int HDR_LEN        = 12,
  parameter int FRAME_INTERVAL = 104,
  parameter int SCROLL_STEP    = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SOF_I,
  input  logic        ENABLE_I,
  input  logic [1:0]  MODE_I,
  input  logic        FIFO_AFULL_I,
  input  logic        FIFO_EMPTY_I,
  output logic [7:0]  DATA_O,
  output logic        DVAL_O,
  output logic        SOP_O,
  output logic        EOF_O,
  output logic [15:0] FRAME_CNT_O,
  output logic [7:0]  SKIP_CNT_O
);

  localparam logic [31:0] FRAME_BYTES = 32'(WIDTH * HEIGHT * 2);
  localparam int DATA_MAX = PAYLOAD_SIZE - HDR_LEN;
  localparam int PW       = $clog2(PAYLOAD_SIZE + 1);
  localparam int CW       = $clog2(WIDTH) + 1;
  localparam int FW       = (FRAME_INTERVAL > 1) ? $clog2(FRAME_INTERVAL) : 1;
  localparam int BAR_W    = WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t          state_q, state_d;
  logic            sof_d0_q, sof_d0_d, sof_d1_q, sof_d1_d;
  logic [FW-1:0]   sof_cnt_q, sof_cnt_d;
  logic [2:0]      ufr_cnt_q, ufr_cnt_d;
  logic [10:0]     sof_num_q, sof_num_d;
  logic [31:0]     pts_q, pts_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic [31:0]     remain_q, remain_d;
  logic [PW-1:0]   pay_left_q, pay_left_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      phase_q, phase_d;
  logic [CW-1:0]   off_q, off_d;
  logic            fid_q, fid_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]      skip_cnt_q, skip_cnt_d;
  logic [31:0]     pts_l_q, pts_l_d;
  logic [10:0]     sof_l_q, sof_l_d;
  logic [1:0]      mode_l_q, mode_l_d;
  logic [7:0]      data_q, data_d;
  logic            dval_q, dval_d;
  logic            sop_q, sop_d;
  logic            eof_q, eof_d;

  logic            sof_rise;
  logic            last_pay;
  logic [PW-1:0]   pay_len;
  logic [7:0]      hdr_byte;
  logic [CW-1:0]   pos_sum, pos;
  logic [2:0]      bar_idx;
  logic [7:0]      bar_y, bar_u, bar_v;
  logic [7:0]      pix_y, pix_u, pix_v, pix_byte;
  logic [CW-1:0]   off_sum;

  assign sof_rise = sof_d0_q & ~sof_d1_q;

  // Remaining bytes do not change during a header, so the EOF bit can be derived live.
  assign last_pay = (remain_q <= 32'(DATA_MAX));
  assign pay_len  = last_pay ? remain_q[PW-1:0] : PW'(DATA_MAX);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx_q)
      4'd0:        hdr_byte = 8'(HDR_LEN);
      4'd1:        hdr_byte = 8'h8C | {6'b0, last_pay, fid_q};
      4'd2, 4'd6:  hdr_byte = pts_l_q[7:0];
      4'd3, 4'd7:  hdr_byte = pts_l_q[15:8];
      4'd4, 4'd8:  hdr_byte = pts_l_q[23:16];
      4'd5, 4'd9:  hdr_byte = pts_l_q[31:24];
      4'd10:       hdr_byte = sof_l_q[7:0];
      4'd11:       hdr_byte = {5'b0, sof_l_q[10:8]};
      default:     hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    pos_sum = col_q + ((mode_l_q == 2'd1) ? off_q : '0);
    pos     = (pos_sum >= CW'(WIDTH)) ? pos_sum - CW'(WIDTH) : pos_sum;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (pos >= CW'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
  end

  always_comb begin
    bar_y = 8'd16;
    bar_u = 8'd128;
    bar_v = 8'd128;
    case (bar_idx)
      3'd0: begin bar_y = 8'd235; bar_u = 8'd128; bar_v = 8'd128; end
      3'd1: begin bar_y = 8'd210; bar_u = 8'd16;  bar_v = 8'd146; end
      3'd2: begin bar_y = 8'd170; bar_u = 8'd166; bar_v = 8'd16;  end
      3'd3: begin bar_y = 8'd145; bar_u = 8'd54;  bar_v = 8'd34;  end
      3'd4: begin bar_y = 8'd106; bar_u = 8'd202; bar_v = 8'd222; end
      3'd5: begin bar_y = 8'd81;  bar_u = 8'd90;  bar_v = 8'd240; end
      3'd6: begin bar_y = 8'd41;  bar_u = 8'd240; bar_v = 8'd110; end
      default: begin bar_y = 8'd16; bar_u = 8'd128; bar_v = 8'd128; end
    endcase
  end

  always_comb begin
    pix_y = bar_y;
    pix_u = 8'd128;
    pix_v = 8'd128;
    case (mode_l_q)
      2'd0, 2'd1: begin pix_y = bar_y; pix_u = bar_u; pix_v = bar_v; end
      2'd2:       pix_y = 8'(col_q);
      default:    pix_y = frame_cnt_q[7:0];
    endcase
    case (phase_q)
      2'd0, 2'd2: pix_byte = pix_y;
      2'd1:       pix_byte = pix_u;
      default:    pix_byte = pix_v;
    endcase
  end

  assign off_sum = off_q + CW'(SCROLL_STEP % WIDTH);

  always_comb begin
    sof_d0_d    = SOF_I;
    sof_d1_d    = sof_d0_q;
    sof_cnt_d   = sof_cnt_q;
    ufr_cnt_d   = ufr_cnt_q;
    sof_num_d   = sof_num_q;
    pts_d       = pts_q + 32'd1;
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    remain_d    = remain_q;
    pay_left_d  = pay_left_q;
    col_d       = col_q;
    phase_d     = phase_q;
    off_d       = off_q;
    fid_d       = fid_q;
    frame_cnt_d = frame_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    pts_l_d     = pts_l_q;
    sof_l_d     = sof_l_q;
    mode_l_d    = mode_l_q;
    data_d      = data_q;
    dval_d      = 1'b0;
    sop_d       = 1'b0;
    eof_d       = 1'b0;

    if (sof_rise) begin
      sof_cnt_d = (sof_cnt_q == FW'(FRAME_INTERVAL - 1)) ? '0 : sof_cnt_q + FW'(1);
      ufr_cnt_d = ufr_cnt_q + 3'd1;
      if (ufr_cnt_q == 3'd7) sof_num_d = sof_num_q + 11'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (sof_rise && (sof_cnt_q == '0) && ENABLE_I) begin
          if (FIFO_EMPTY_I) begin
            state_d   = ST_HDR;
            hdr_idx_d = 4'd0;
            remain_d  = FRAME_BYTES;
            col_d     = '0;
            phase_d   = 2'd0;
            pts_l_d   = pts_q;
            sof_l_d   = sof_num_q;
            mode_l_d  = MODE_I;
          end else if (skip_cnt_q != 8'hFF) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
          end
        end
      end
      ST_HDR: begin
        if (!FIFO_AFULL_I) begin
          dval_d = 1'b1;
          sop_d  = (hdr_idx_q == 4'd0);
          data_d = hdr_byte;
          if (hdr_idx_q == 4'd11) begin
            state_d    = ST_DATA;
            pay_left_d = pay_len;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (!FIFO_AFULL_I) begin
          dval_d     = 1'b1;
          data_d     = pix_byte;
          remain_d   = remain_q - 32'd1;
          pay_left_d = pay_left_q - PW'(1);
          phase_d    = phase_q + 2'd1;
          if (phase_q == 2'd3) col_d = (col_q == CW'(WIDTH - 2)) ? '0 : col_q + CW'(2);
          if (pay_left_q == PW'(1)) begin
            if (remain_q == 32'd1) begin
              state_d     = ST_IDLE;
              eof_d       = 1'b1;
              fid_d       = ~fid_q;
              frame_cnt_d = frame_cnt_q + 16'd1;
              off_d       = (off_sum >= CW'(WIDTH)) ? off_sum - CW'(WIDTH) : off_sum;
            end else begin
              state_d   = ST_HDR;
              hdr_idx_d = 4'd0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      sof_d0_q    <= 1'b0;
      sof_d1_q    <= 1'b0;
      sof_cnt_q   <= '0;
      ufr_cnt_q   <= 3'd0;
      sof_num_q   <= 11'd0;
      pts_q       <= 32'd0;
      hdr_idx_q   <= 4'd0;
      remain_q    <= 32'd0;
      pay_left_q  <= '0;
      col_q       <= '0;
      phase_q     <= 2'd0;
      off_q       <= '0;
      fid_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      skip_cnt_q  <= 8'd0;
      pts_l_q     <= 32'd0;
      sof_l_q     <= 11'd0;
      mode_l_q    <= 2'd0;
      data_q      <= 8'd0;
      dval_q      <= 1'b0;
      sop_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sof_d0_q    <= sof_d0_d;
      sof_d1_q    <= sof_d1_d;
      sof_cnt_q   <= sof_cnt_d;
      ufr_cnt_q   <= ufr_cnt_d;
      sof_num_q   <= sof_num_d;
      pts_q       <= pts_d;
      hdr_idx_q   <= hdr_idx_d;
      remain_q    <= remain_d;
      pay_left_q  <= pay_left_d;
      col_q       <= col_d;
      phase_q     <= phase_d;
      off_q       <= off_d;
      fid_q       <= fid_d;
      frame_cnt_q <= frame_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      pts_l_q     <= pts_l_d;
      sof_l_q     <= sof_l_d;
      mode_l_q    <= mode_l_d;
      data_q      <= data_d;
      dval_q      <= dval_d;
      sop_q       <= sop_d;
      eof_q       <= eof_d;
    end
  end

  assign DATA_O      = data_q;
  assign DVAL_O      = dval_q;
  assign SOP_O       = sop_q;
  assign EOF_O       = eof_q;
  assign FRAME_CNT_O = frame_cnt_q;
  assign SKIP_CNT_O  = skip_cnt_q;

endmodule

// File: tb/tb_uvc_payload_gen.sv
// Scoreboard bench for uvc_payload_gen: a byte-level frame model fills a queue at each
// frame start; a monitor pops and compares every DVAL_O byte.
module tb_uvc_payload_gen;
  localparam int W = 16, H = 2, PS = 32, HL = 12, FI = 4, SS = 2;
  localparam int FB = W * H * 2, DMAX = PS - HL;

  logic        CLK_I = 1'b0;
  logic        RST_I, SOF_I, ENABLE_I, FIFO_AFULL_I, FIFO_EMPTY_I;
  logic [1:0]  MODE_I;
  logic [7:0]  DATA_O, SKIP_CNT_O;
  logic        DVAL_O, SOP_O, EOF_O;
  logic [15:0] FRAME_CNT_O;

  uvc_payload_gen #(.WIDTH(W), .HEIGHT(H), .PAYLOAD_SIZE(PS), .HDR_LEN(HL),
                    .FRAME_INTERVAL(FI), .SCROLL_STEP(SS)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .SOF_I(SOF_I), .ENABLE_I(ENABLE_I), .MODE_I(MODE_I),
    .FIFO_AFULL_I(FIFO_AFULL_I), .FIFO_EMPTY_I(FIFO_EMPTY_I), .DATA_O(DATA_O),
    .DVAL_O(DVAL_O), .SOP_O(SOP_O), .EOF_O(EOF_O), .FRAME_CNT_O(FRAME_CNT_O),
    .SKIP_CNT_O(SKIP_CNT_O));

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {logic [7:0] d; logic sop; logic eof;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int tests, fails;

  int bar_y[8] = '{235, 210, 170, 145, 106, 81, 41, 16};
  int bar_u[8] = '{128, 16, 166, 54, 202, 90, 240, 128};
  int bar_v[8] = '{128, 146, 16, 34, 222, 240, 110, 128};

  // Reference model state
  int unsigned cyc_m;
  int rises_m, fcnt_m, off_m, skip_m;
  bit fid_m;
  int stall_mode, st_cnt;
  logic afull_s;

  always @(posedge CLK_I) cyc_m <= RST_I ? 0 : cyc_m + 1;

  function automatic void pushb(logic [7:0] d, bit s, bit e);
    exp_t x;
    x.d = d; x.sop = s; x.eof = e;
    exp_q.push_back(x);
  endfunction

  function automatic logic [7:0] pix_exp(int b, int mode);
    int col = ((b / 4) * 2) % W;
    int ph  = b % 4;
    int p, bar, y, u, v;
    if (mode <= 1) begin
      p   = (mode == 1) ? (col + off_m) % W : col;
      bar = p / (W / 8);
      y = bar_y[bar]; u = bar_u[bar]; v = bar_v[bar];
    end else begin
      y = (mode == 2) ? (col % 256) : (fcnt_m % 256);
      u = 128; v = 128;
    end
    if (ph == 0 || ph == 2) return 8'(y);
    if (ph == 1) return 8'(u);
    return 8'(v);
  endfunction

  function automatic void push_frame(int mode, int unsigned pts, int sofn);
    int remain = FB;
    int b = 0;
    int n;
    while (remain > 0) begin
      n = (remain > DMAX) ? DMAX : remain;
      pushb(8'(HL), 1'b1, 1'b0);
      pushb(8'h8C | ((remain <= DMAX) ? 8'h02 : 8'h00) | (fid_m ? 8'h01 : 8'h00), 1'b0, 1'b0);
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 4; i++) pushb(8'(pts >> (8 * i)), 1'b0, 1'b0);
      pushb(8'(sofn), 1'b0, 1'b0);
      pushb(8'((sofn >> 8) & 7), 1'b0, 1'b0);
      for (int j = 0; j < n; j++) begin
        pushb(pix_exp(b, mode), 1'b0, b == FB - 1);
        b++;
      end
      remain -= n;
    end
    fid_m  = ~fid_m;
    fcnt_m = (fcnt_m + 1) % 65536;
    off_m  = (off_m + SS) % W;
  endfunction

  always @(posedge CLK_I) afull_s <= FIFO_AFULL_I;

  always @(negedge CLK_I) begin
    case (stall_mode)
      1:       FIFO_AFULL_I = ((st_cnt / 3) % 2 == 1);
      2:       FIFO_AFULL_I = ($urandom_range(0, 3) == 0);
      default: FIFO_AFULL_I = 1'b0;
    endcase
    st_cnt = st_cnt + 1;
  end

  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (afull_s === 1'b1) begin
        tests++;
        if (DVAL_O !== 1'b0) begin
          fails++;
          $display("FAIL stall_dval: DVAL_O=%b, required 0 after an AFULL cycle", DVAL_O);
        end
      end
      if (DVAL_O === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got data=%02h sop=%b eof=%b, none expected",
                   DATA_O, SOP_O, EOF_O);
        end else begin
          mon_e = exp_q.pop_front();
          if ({DATA_O, SOP_O, EOF_O} !== {mon_e.d, mon_e.sop, mon_e.eof}) begin
            fails++;
            $display("FAIL byte: got data=%02h sop=%b eof=%b, required data=%02h sop=%b eof=%b",
                     DATA_O, SOP_O, EOF_O, mon_e.d, mon_e.sop, mon_e.eof);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic sof_rise(input bit en, input bit empty, input logic [1:0] mode);
    int unsigned pts_e;
    int sofn;
    bit slot;
    @(negedge CLK_I);
    SOF_I = 1'b1; ENABLE_I = en; FIFO_EMPTY_I = empty; MODE_I = mode;
    slot = (rises_m % FI == 0);
    sofn = (rises_m / 8) % 2048;
    @(negedge CLK_I);
    pts_e = cyc_m;
    SOF_I = 1'b0;
    if (slot && en) begin
      if (empty) push_frame(int'(mode), pts_e, sofn);
      else if (skip_m < 255) skip_m++;
    end
    rises_m++;
    @(negedge CLK_I);
    // Control inputs wander mid-frame; they must not affect the frame in flight.
    MODE_I       = 2'($urandom_range(0, 3));
    ENABLE_I     = 1'($urandom_range(0, 1));
    FIFO_EMPTY_I = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge CLK_I);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d bytes still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge CLK_I);
    chk("frame_cnt", 32'(FRAME_CNT_O), 32'(fcnt_m));
    chk("skip_cnt", 32'(SKIP_CNT_O), 32'(skip_m));
  endtask

  task automatic slot(input bit en, input bit empty, input logic [1:0] mode);
    sof_rise(en, empty, mode);
    for (int i = 1; i < FI; i++)
      sof_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    wait_drain();
  endtask

  initial begin
    int n;
    tests = 0; fails = 0; stall_mode = 0; st_cnt = 0;
    fid_m = 1'b0; fcnt_m = 0; off_m = 0; skip_m = 0; rises_m = 0;
    RST_I = 1'b1; SOF_I = 1'b0; ENABLE_I = 1'b0; FIFO_EMPTY_I = 1'b1; MODE_I = 2'd0;
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    chk("reset_dval", 32'(DVAL_O), 32'd0);
    chk("reset_data", 32'(DATA_O), 32'd0);
    chk("reset_frame_cnt", 32'(FRAME_CNT_O), 32'd0);
    chk("reset_skip_cnt", 32'(SKIP_CNT_O), 32'd0);

    slot(1'b1, 1'b1, 2'd0);
    slot(1'b1, 1'b1, 2'd1);
    slot(1'b1, 1'b0, 2'd0);
    slot(1'b0, 1'b1, 2'd0);

    stall_mode = 1;
    slot(1'b1, 1'b1, 2'd0);
    slot(1'b1, 1'b1, 2'd1);
    slot(1'b1, 1'b1, 2'd2);
    slot(1'b1, 1'b1, 2'd3);

    stall_mode = 2;
    for (int i = 0; i < 24; i++)
      slot(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));

    stall_mode = 0;
    for (int i = 0; i < 300; i++) begin
      sof_rise(1'b1, 1'b0, 2'($urandom_range(0, 3)));
      for (int k = 1; k < FI; k++)
        sof_rise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    wait_drain();
    chk("skip_saturated", 32'(SKIP_CNT_O), 32'd255);

    sof_rise(1'b1, 1'b1, 2'd0);
    n = 0;
    while (exp_q.size() >= 60 && n < 1000) begin
      @(negedge CLK_I);
      n++;
    end
    chk("reached_mid_data", 32'(exp_q.size() < 60), 32'd1);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
    chk("rst_dval", 32'(DVAL_O), 32'd0);
    chk("rst_eof", 32'(EOF_O), 32'd0);
    chk("rst_frame_cnt", 32'(FRAME_CNT_O), 32'd0);
    chk("rst_skip_cnt", 32'(SKIP_CNT_O), 32'd0);
    exp_q.delete();
    fid_m = 1'b0; fcnt_m = 0; off_m = 0; skip_m = 0; rises_m = 0;
    SOF_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;

    slot(1'b1, 1'b1, 2'd0);
    slot(1'b1, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
